seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning pattern length in bits (legal 2..16).
REQ-002 SHALL have parameter PATTERN, default 4'b1001, meaning the power-up pattern; the first bit received is compared against bit WIDTH-1.
REQ-003 SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed and 0 = the history restarts after each match.
REQ-004 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-005 SHALL have port clock, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-007 SHALL have port in, input, 1 bit, meaning serial data bit, sampled each rising edge while enable=1.
REQ-008 SHALL have port enable, input, 1 bit, meaning sample qualifier.
REQ-009 SHALL have port load_pattern, input, 1 bit, meaning replace the active pattern with pattern_in.
REQ-010 SHALL have port pattern_in, input, WIDTH bits, meaning new pattern value.
REQ-011 SHALL have port clear_count, input, 1 bit, meaning zero the match counter.
REQ-012 SHALL have port out, output, 1 bit, meaning registered match flag.
REQ-013 SHALL have port match_count, output, CNT_W bits, meaning saturating count of matches.
REQ-014 SHALL have port count_sat, output, 1 bit, meaning high while match_count is all ones.

Function
REQ-015 SHALL keep a WIDTH-bit history register and a fill counter (0..WIDTH, saturating at WIDTH) of valid bits held.
REQ-016 On an edge with enable=1 and load_pattern=0, history SHALL shift left with in entering bit 0, and fill SHALL increment up to WIDTH.
REQ-017 On that same edge, out SHALL be set to 1 iff the shifted history equals the active pattern and the incremented fill equals WIDTH; otherwise out SHALL be set to 0.
REQ-018 out SHALL therefore be high for exactly the cycle following the edge that sampled the final pattern bit (latency 1 cycle, Moore-style registered output).
REQ-019 Consecutive matches SHALL hold out high on consecutive cycles (e.g. pattern 11 with in held at 1).
REQ-020 With OVERLAP=0, fill SHALL return to 0 on a matching edge; history contents are don't-care afterwards.
REQ-021 With OVERLAP=1, fill SHALL stay at WIDTH after a match.
REQ-022 While enable=0, history and fill SHALL hold, in SHALL be ignored, and out SHALL be 0 on the next edge.
REQ-023 load_pattern=1 SHALL, on that edge, load pattern_in, clear history and fill to 0, and drive out to 0.
REQ-024 load_pattern SHALL take priority over enable; the bit on in during a load edge is discarded.
REQ-025 A bit stream shorter than WIDTH since reset, load, or a non-overlap match SHALL never match, even when the pattern has leading zeros.
REQ-026 match_count SHALL increment on each edge where out is set to 1, saturating at 2^CNT_W-1 with no wrap.
REQ-027 count_sat SHALL be combinational from match_count.
REQ-028 clear_count=1 SHALL set match_count to 0 and SHALL take priority over a simultaneous increment.
REQ-029 clear_count SHALL NOT affect history, fill, pattern or out.

Reset
REQ-030 When reset=1 at an edge, the block SHALL set: history=0, fill=0, active pattern=PATTERN, out=0, match_count=0 (so count_sat=0).
REQ-031 reset SHALL override load_pattern, enable and clear_count.
REQ-032 reset asserted mid-sequence SHALL discard all partial progress.

Verification
REQ-033 Basic match (defaults): reset, then in=1,0,0,1 with enable=1 -> out=0 after the first three edges and out=1 after the fourth edge, match_count=1; holding in=1 -> out=0 next cycle.
REQ-034 Overlap: stream 1,0,0,1,0,0,1 -> with OVERLAP=1, out pulses after bits 4 and 7 and match_count=2; with OVERLAP=0, a single pulse after bit 4 and match_count=1.
REQ-035 Fill guard: load pattern 4'b0001, then stream 0,0,1 -> out stays 0; stream 0,0,0,1 after a fresh load -> out=1 after the fourth bit.
REQ-036 Enable gap: stream 1,0, then enable=0 for 3 cycles with in=1, then stream 0,1 -> out=0 throughout the gap and out=1 after the final bit.
REQ-037 Saturation and clear: with CNT_W=2, drive 4 matches -> match_count=3 and count_sat=1; assert clear_count together with a fifth match -> match_count=0 and out=1.
REQ-038 Reset mid-sequence: stream 1,0,0, assert reset for one edge, then in=1 -> out=0 and match_count=0.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial bit-pattern detector with a runtime-loadable pattern, a fill guard
//   so short streams never match, optional overlapping matches and a
//   saturating match counter.
//
// Ports
//   clock        : single clock, all state updates on rising edge
//   reset        : synchronous active-high reset
//   in           : serial data bit, sampled while enable=1
//   enable       : sample qualifier
//   load_pattern : load pattern_in as the active pattern, restart history
//   pattern_in   : new pattern value (WIDTH bits)
//   clear_count  : zero the match counter
//   out          : registered match flag (one cycle after the final bit)
//   match_count  : saturating count of matches
//   count_sat    : high while match_count is all ones
module seq_detect_param #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1001,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic             enable,
  input  logic             load_pattern,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             clear_count,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int               FILL_W   = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WIDTH-1:0]  pat_q, pat_d;
  logic              out_q, out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  // The first received bit ends up in the MSB after WIDTH shifts, so it is
  // compared against PATTERN[WIDTH-1].
  assign hist_shift = {hist_q[WIDTH-2:0], in};
  assign fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  // The fill check keeps a cleared history from matching a pattern with
  // leading zeros before WIDTH real bits have arrived.
  assign hit        = (hist_shift == pat_q) && (fill_inc == FILL_MAX);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    out_d  = 1'b0;
    if (load_pattern) begin
      pat_d  = pattern_in;
      hist_d = '0;
      fill_d = '0;
    end else if (enable) begin
      hist_d = hist_shift;
      out_d  = hit;
      if (hit && !OVERLAP) begin
        fill_d = '0;
      end else begin
        fill_d = fill_inc;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = '0;
    end else if (out_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign count_sat   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param. Three instances share the stimulus:
//   u_a : defaults (overlap on, 8-bit counter)
//   u_b : OVERLAP=0
//   u_c : CNT_W=2 for saturation
module tb_seq_detect_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tb_in = 1'b0;
  logic       enable = 1'b0;
  logic       load_pattern = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic       clear_count = 1'b0;

  logic       out_a, sat_a;
  logic [7:0] cnt_a;
  logic       out_b, sat_b;
  logic [7:0] cnt_b;
  logic       out_c, sat_c;
  logic [1:0] cnt_c;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  seq_detect_param u_a (
    .clock(clock), .reset(reset), .in(tb_in), .enable(enable),
    .load_pattern(load_pattern), .pattern_in(pattern_in), .clear_count(clear_count),
    .out(out_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detect_param #(.OVERLAP(1'b0)) u_b (
    .clock(clock), .reset(reset), .in(tb_in), .enable(enable),
    .load_pattern(load_pattern), .pattern_in(pattern_in), .clear_count(clear_count),
    .out(out_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  seq_detect_param #(.CNT_W(2)) u_c (
    .clock(clock), .reset(reset), .in(tb_in), .enable(enable),
    .load_pattern(load_pattern), .pattern_in(pattern_in), .clear_count(clear_count),
    .out(out_c), .match_count(cnt_c), .count_sat(sat_c)
  );

  // Drive one cycle's inputs at the falling edge, return 1ns after the rising edge.
  task automatic step(input logic b, input logic en, input logic ld,
                      input logic [3:0] p, input logic clr, input logic rst);
    @(negedge clock);
    tb_in = b; enable = en; load_pattern = ld; pattern_in = p;
    clear_count = clr; reset = rst;
    @(posedge clock);
    #1;
  endtask

  task automatic bit_in(input logic b);
    step(b, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    // reset overrides enable/load/clear held high with it
    step(1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
    checks += 5;
    if (out_a !== 1'b0) begin errors++; $display("FAIL reset_out out=%0b exp=0", out_a); end
    if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_cnt cnt=%0d exp=0", cnt_a); end
    if (sat_a !== 1'b0) begin errors++; $display("FAIL reset_sat sat=%0b exp=0", sat_a); end
    if (cnt_c !== 2'd0) begin errors++; $display("FAIL reset_cnt_c cnt=%0d exp=0", cnt_c); end
    if (sat_c !== 1'b0) begin errors++; $display("FAIL reset_sat_c sat=%0b exp=0", sat_c); end
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    // pattern must still be 1001 (load during reset ignored)
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    checks++;
    if (out_a !== 1'b1) begin errors++; $display("FAIL reset_pattern out=%0b exp=1", out_a); end
  endtask

  task automatic test_basic();
    logic seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bit_in(seq[i]);
      checks++;
      if (out_a !== exp[i]) begin errors++; $display("FAIL basic_out[%0d] out=%0b exp=%0b", i, out_a, exp[i]); end
    end
    checks++;
    if (cnt_a !== 8'd1) begin errors++; $display("FAIL basic_cnt cnt=%0d exp=1", cnt_a); end
    bit_in(1'b1);
    checks++;
    if (out_a !== 1'b0) begin errors++; $display("FAIL basic_after out=%0b exp=0", out_a); end
  endtask

  task automatic test_overlap();
    logic seq   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_a [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_b [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bit_in(seq[i]);
      checks += 2;
      if (out_a !== exp_a[i]) begin errors++; $display("FAIL ovl_out_a[%0d] out=%0b exp=%0b", i, out_a, exp_a[i]); end
      if (out_b !== exp_b[i]) begin errors++; $display("FAIL ovl_out_b[%0d] out=%0b exp=%0b", i, out_b, exp_b[i]); end
    end
    checks += 2;
    if (cnt_a !== 8'd2) begin errors++; $display("FAIL ovl_cnt_a cnt=%0d exp=2", cnt_a); end
    if (cnt_b !== 8'd1) begin errors++; $display("FAIL ovl_cnt_b cnt=%0d exp=1", cnt_b); end
  endtask

  task automatic test_fill_guard();
    logic seq [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    // in=1 during the load edge must be discarded
    step(1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    checks++;
    if (out_a !== 1'b0) begin errors++; $display("FAIL fill_load out=%0b exp=0", out_a); end
    bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    checks++;
    if (out_a !== 1'b0) begin errors++; $display("FAIL fill_short out=%0b exp=0", out_a); end
    step(1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bit_in(seq[i]);
      checks++;
      if (out_a !== exp[i]) begin errors++; $display("FAIL fill_full[%0d] out=%0b exp=%0b", i, out_a, exp[i]); end
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    bit_in(1'b1); bit_in(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
      checks++;
      if (out_a !== 1'b0) begin errors++; $display("FAIL gap_out[%0d] out=%0b exp=0", i, out_a); end
    end
    bit_in(1'b0);
    checks++;
    if (out_a !== 1'b0) begin errors++; $display("FAIL gap_pre out=%0b exp=0", out_a); end
    bit_in(1'b1);
    checks++;
    if (out_a !== 1'b1) begin errors++; $display("FAIL gap_final out=%0b exp=1", out_a); end
    // a match on the last enabled edge must not persist through a disabled edge
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    checks++;
    if (out_a !== 1'b0) begin errors++; $display("FAIL gap_drop out=%0b exp=0", out_a); end
  endtask

  task automatic test_saturation();
    do_reset();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    checks += 2;
    if (cnt_c !== 2'd1) begin errors++; $display("FAIL sat_cnt1 cnt=%0d exp=1", cnt_c); end
    if (sat_c !== 1'b0) begin errors++; $display("FAIL sat_flag1 sat=%0b exp=0", sat_c); end
    for (int i = 0; i < 3; i++) begin
      bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    end
    checks += 4;
    if (out_c !== 1'b1) begin errors++; $display("FAIL sat_out4 out=%0b exp=1", out_c); end
    if (cnt_c !== 2'd3) begin errors++; $display("FAIL sat_cnt4 cnt=%0d exp=3", cnt_c); end
    if (sat_c !== 1'b1) begin errors++; $display("FAIL sat_flag4 sat=%0b exp=1", sat_c); end
    if (cnt_a !== 8'd4) begin errors++; $display("FAIL sat_cnt_a cnt=%0d exp=4", cnt_a); end
    bit_in(1'b0); bit_in(1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    checks += 4;
    if (out_c !== 1'b1) begin errors++; $display("FAIL clr_out out=%0b exp=1", out_c); end
    if (cnt_c !== 2'd0) begin errors++; $display("FAIL clr_cnt cnt=%0d exp=0", cnt_c); end
    if (sat_c !== 1'b0) begin errors++; $display("FAIL clr_sat sat=%0b exp=0", sat_c); end
    if (cnt_a !== 8'd0) begin errors++; $display("FAIL clr_cnt_a cnt=%0d exp=0", cnt_a); end
    // history and fill survive the clear
    bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    checks += 2;
    if (out_c !== 1'b1) begin errors++; $display("FAIL clr_hist out=%0b exp=1", out_c); end
    if (cnt_c !== 2'd1) begin errors++; $display("FAIL clr_recount cnt=%0d exp=1", cnt_c); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    bit_in(1'b1);
    checks += 2;
    if (out_a !== 1'b0) begin errors++; $display("FAIL rstmid_out out=%0b exp=0", out_a); end
    if (cnt_a !== 8'd0) begin errors++; $display("FAIL rstmid_cnt cnt=%0d exp=0", cnt_a); end
  endtask

  task automatic test_back_to_back();
    logic exp_a [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic exp_b [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bit_in(1'b1);
      checks += 2;
      if (out_a !== exp_a[i]) begin errors++; $display("FAIL b2b_out_a[%0d] out=%0b exp=%0b", i, out_a, exp_a[i]); end
      if (out_b !== exp_b[i]) begin errors++; $display("FAIL b2b_out_b[%0d] out=%0b exp=%0b", i, out_b, exp_b[i]); end
    end
    bit_in(1'b1);
    checks += 3;
    if (out_b !== 1'b1) begin errors++; $display("FAIL b2b_out_b8 out=%0b exp=1", out_b); end
    if (cnt_a !== 8'd5) begin errors++; $display("FAIL b2b_cnt_a cnt=%0d exp=5", cnt_a); end
    if (cnt_b !== 8'd2) begin errors++; $display("FAIL b2b_cnt_b cnt=%0d exp=2", cnt_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_fill_guard();
    test_enable_gap();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
